wordle_game_ctrl: RTL and testbench

Parametrised Wordle game controller. It replaces the fixed five-letter, six-guess state machine with a WORD_LEN/MAX_GUESSES/CHAR_W-generic engine. The engine has editable letter entry (letter/backspace/enter handshake) and a sequential scorer that produces per-letter green/yellow/grey feedback with correct duplicate-letter handling. It sits between the keyboard decoder and the display/VGA logic; the target word is supplied externally (word-of-day selector) and sampled on start.

---
 rtl/wordle_game_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_wordle_game_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wordle_game_ctrl.sv
// wordle_game_ctrl: parametrised Wordle game engine.
//
// Collects a guess one key action per cycle (letter / backspace / enter),
// then scores it against a target latched at start: one cycle for greens,
// WORD_LEN cycles for yellows (one position per cycle, lowest unused target
// match wins, so duplicate letters are credited only as often as the target
// holds them), then a single REPORT cycle that pulses fb_valid.
//
// Ports:
//   Clk, reset          clock, async active-low reset
//   start, target_word  begin a new game (from IDLE/DONE), latch the answer
//   key_valid/key_char  letter entry
//   key_bksp, key_enter delete last letter, submit guess (enter > bksp > letter)
//   key_ready           high only while accepting keys
//   guess_word          guess buffer, letter 0 in the MS slice, empty slots 0
//   letter_cnt          letters in buffer
//   guess_num           completed guesses
//   fb_valid, fb_code   feedback pulse; pair per letter, 10 green / 01 yellow / 00 grey
//   enter_reject        pulse after enter on a short guess
//   busy                scoring in progress
//   win, lose, done     game outcome, valid while done
module wordle_game_ctrl #(
  parameter int unsigned WORD_LEN    = 5,
  parameter int unsigned MAX_GUESSES = 6,
  parameter int unsigned CHAR_W      = 8
) (
  input  logic                               Clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [WORD_LEN*CHAR_W-1:0]         target_word,
  input  logic                               key_valid,
  input  logic [CHAR_W-1:0]                  key_char,
  input  logic                               key_bksp,
  input  logic                               key_enter,
  output logic                               key_ready,
  output logic [WORD_LEN*CHAR_W-1:0]         guess_word,
  output logic [$clog2(WORD_LEN+1)-1:0]      letter_cnt,
  output logic [$clog2(MAX_GUESSES+1)-1:0]   guess_num,
  output logic                               fb_valid,
  output logic [2*WORD_LEN-1:0]              fb_code,
  output logic                               enter_reject,
  output logic                               busy,
  output logic                               win,
  output logic                               lose,
  output logic                               done
);

  localparam int unsigned CntW = $clog2(WORD_LEN + 1);
  localparam int unsigned IdxW = $clog2(WORD_LEN);
  localparam int unsigned GnW  = $clog2(MAX_GUESSES + 1);

  localparam logic [CntW-1:0] FullCnt = CntW'(WORD_LEN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_LEN - 1);
  localparam logic [GnW-1:0]  MaxGn   = GnW'(MAX_GUESSES);

  typedef enum logic [2:0] {StIdle, StEntry, StScoreG, StScoreY, StReport, StDone} state_e;

  state_e                state_q;
  logic [CHAR_W-1:0]     guess_q  [WORD_LEN];
  logic [CHAR_W-1:0]     target_q [WORD_LEN];
  logic [1:0]            fbw_q    [WORD_LEN];
  logic [CntW-1:0]       cnt_q;
  logic [GnW-1:0]        gn_q;
  logic [IdxW-1:0]       idx_q;
  logic [WORD_LEN-1:0]   green_q;
  logic [WORD_LEN-1:0]   used_q;
  logic [2*WORD_LEN-1:0] fb_code_q;
  logic                  fb_valid_q;
  logic                  rej_q;
  logic                  win_q;
  logic                  lose_q;

  // Yellow search for the position currently addressed by idx_q
  logic [CHAR_W-1:0]     cur_guess;
  logic                  cur_green;
  logic [WORD_LEN-1:0]   match_sel;
  logic                  yellow_hit;
  logic [1:0]            fbw_next [WORD_LEN];
  logic [2*WORD_LEN-1:0] fb_final;

  always_comb begin
    cur_guess = '0;
    cur_green = 1'b0;
    for (int i = 0; i < int'(WORD_LEN); i++) begin
      if (IdxW'(i) == idx_q) begin
        cur_guess = guess_q[i];
        cur_green = green_q[i];
      end
    end
    // Descending scan so the lowest matching unused target slot is kept
    match_sel = '0;
    for (int j = int'(WORD_LEN) - 1; j >= 0; j--) begin
      if (target_q[j] == cur_guess && !used_q[j]) begin
        match_sel    = '0;
        match_sel[j] = 1'b1;
      end
    end
    yellow_hit = !cur_green && (match_sel != '0);
    fb_final   = '0;
    for (int i = 0; i < int'(WORD_LEN); i++) begin
      fbw_next[i] = fbw_q[i];
      if (yellow_hit && IdxW'(i) == idx_q) fbw_next[i] = 2'b01;
      fb_final[(int'(WORD_LEN) - 1 - i) * 2 +: 2] = fbw_next[i];
    end
  end

  always_comb begin
    guess_word = '0;
    for (int i = 0; i < int'(WORD_LEN); i++) begin
      guess_word[(int'(WORD_LEN) - 1 - i) * int'(CHAR_W) +: CHAR_W] = guess_q[i];
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gn_q       <= '0;
      idx_q      <= '0;
      green_q    <= '0;
      used_q     <= '0;
      fb_code_q  <= '0;
      fb_valid_q <= 1'b0;
      rej_q      <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      for (int i = 0; i < int'(WORD_LEN); i++) begin
        guess_q[i]  <= '0;
        target_q[i] <= '0;
        fbw_q[i]    <= '0;
      end
    end else begin
      fb_valid_q <= 1'b0;
      rej_q      <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StEntry;
            cnt_q     <= '0;
            gn_q      <= '0;
            fb_code_q <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            for (int i = 0; i < int'(WORD_LEN); i++) begin
              guess_q[i]  <= '0;
              target_q[i] <= target_word[(int'(WORD_LEN) - 1 - i) * int'(CHAR_W) +: CHAR_W];
            end
          end
        end
        StEntry: begin
          if (key_enter) begin
            if (cnt_q == FullCnt) state_q <= StScoreG;
            else                  rej_q   <= 1'b1;
          end else if (key_bksp) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
              for (int i = 0; i < int'(WORD_LEN); i++) begin
                if (CntW'(i + 1) == cnt_q) guess_q[i] <= '0;
              end
            end
          end else if (key_valid) begin
            if (cnt_q < FullCnt) begin
              cnt_q <= cnt_q + 1'b1;
              for (int i = 0; i < int'(WORD_LEN); i++) begin
                if (CntW'(i) == cnt_q) guess_q[i] <= key_char;
              end
            end
          end
        end
        StScoreG: begin
          for (int i = 0; i < int'(WORD_LEN); i++) begin
            green_q[i] <= (guess_q[i] == target_q[i]);
            used_q[i]  <= (guess_q[i] == target_q[i]);
            fbw_q[i]   <= (guess_q[i] == target_q[i]) ? 2'b10 : 2'b00;
          end
          idx_q   <= '0;
          state_q <= StScoreY;
        end
        StScoreY: begin
          for (int i = 0; i < int'(WORD_LEN); i++) fbw_q[i] <= fbw_next[i];
          if (yellow_hit) used_q <= used_q | match_sel;
          if (idx_q == LastIdx) begin
            fb_code_q  <= fb_final;
            fb_valid_q <= 1'b1;
            if (gn_q < MaxGn) gn_q <= gn_q + 1'b1;
            state_q    <= StReport;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StReport: begin
          // guess_num already holds the new count here
          if (&green_q) begin
            win_q   <= 1'b1;
            state_q <= StDone;
          end else if (gn_q == MaxGn) begin
            lose_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q   <= '0;
            state_q <= StEntry;
            for (int i = 0; i < int'(WORD_LEN); i++) guess_q[i] <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign key_ready    = (state_q == StEntry);
  assign busy         = (state_q == StScoreG) || (state_q == StScoreY) || (state_q == StReport);
  assign done         = (state_q == StDone);
  assign letter_cnt   = cnt_q;
  assign guess_num    = gn_q;
  assign fb_valid     = fb_valid_q;
  assign fb_code      = fb_code_q;
  assign enter_reject = rej_q;
  assign win          = win_q;
  assign lose         = lose_q;

endmodule

// File: tb/tb_wordle_game_ctrl.sv
module tb_wordle_game_ctrl;

  localparam int WL = 5;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  always #5 Clk = ~Clk;

  // Default-parameter instance
  logic        start, key_valid, key_bksp, key_enter;
  logic [39:0] target_word;
  logic [7:0]  key_char;
  logic        key_ready, fb_valid, enter_reject, busy, win, lose, done;
  logic [39:0] guess_word;
  logic [2:0]  letter_cnt, guess_num;
  logic [9:0]  fb_code;

  wordle_game_ctrl u_dut (
    .Clk(Clk), .reset(reset), .start(start), .target_word(target_word),
    .key_valid(key_valid), .key_char(key_char), .key_bksp(key_bksp), .key_enter(key_enter),
    .key_ready(key_ready), .guess_word(guess_word), .letter_cnt(letter_cnt),
    .guess_num(guess_num), .fb_valid(fb_valid), .fb_code(fb_code),
    .enter_reject(enter_reject), .busy(busy), .win(win), .lose(lose), .done(done)
  );

  // Reduced instance: 3 letters, 2 guesses
  logic        s_start, s_key_valid, s_key_bksp, s_key_enter;
  logic [23:0] s_target_word;
  logic [7:0]  s_key_char;
  logic        s_key_ready, s_fb_valid, s_enter_reject, s_busy, s_win, s_lose, s_done;
  logic [23:0] s_guess_word;
  logic [1:0]  s_letter_cnt, s_guess_num;
  logic [5:0]  s_fb_code;

  wordle_game_ctrl #(.WORD_LEN(3), .MAX_GUESSES(2), .CHAR_W(8)) u_dut_s (
    .Clk(Clk), .reset(reset), .start(s_start), .target_word(s_target_word),
    .key_valid(s_key_valid), .key_char(s_key_char), .key_bksp(s_key_bksp),
    .key_enter(s_key_enter), .key_ready(s_key_ready), .guess_word(s_guess_word),
    .letter_cnt(s_letter_cnt), .guess_num(s_guess_num), .fb_valid(s_fb_valid),
    .fb_code(s_fb_code), .enter_reject(s_enter_reject), .busy(s_busy), .win(s_win),
    .lose(s_lose), .done(s_done)
  );

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0] fb;
    int         at;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every fb_valid pulse must match the oldest pending guess
  always @(negedge Clk) begin : fb_mon
    exp_t e;
    if (fb_valid) begin
      if (sb_q.size() == 0) begin
        check("fb_unexpected", 64'(fb_valid), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check("fb_code", 64'(fb_code), 64'(e.fb));
        check("fb_latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge
  task automatic key(input logic v, input logic [7:0] ch, input logic b, input logic e);
    key_valid = v; key_char = ch; key_bksp = b; key_enter = e;
    @(posedge Clk); #1;
    key_valid = 1'b0; key_char = '0; key_bksp = 1'b0; key_enter = 1'b0;
  endtask

  task automatic type_word(input logic [39:0] w);
    for (int i = 0; i < 5; i++) key(1'b1, w[39-8*i -: 8], 1'b0, 1'b0);
  endtask

  task automatic submit(input logic [9:0] fb, input logic all_keys);
    exp_t e;
    e.fb = fb;
    e.at = cyc + 2 + WL;
    sb_q.push_back(e);
    if (all_keys) key(1'b1, "Z", 1'b1, 1'b1);
    else          key(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_fb();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("fb_timeout", 64'(sb_q.size()), 64'(0));
      sb_q.delete();
    end
  endtask

  task automatic start_game(input logic [39:0] w);
    target_word = w; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic s_key(input logic [7:0] ch);
    s_key_valid = 1'b1; s_key_char = ch;
    @(posedge Clk); #1;
    s_key_valid = 1'b0; s_key_char = '0;
  endtask

  task automatic s_type(input logic [23:0] w);
    for (int i = 0; i < 3; i++) s_key(w[23-8*i -: 8]);
  endtask

  task automatic s_submit(input logic [5:0] fb);
    int t;
    int n;
    t = cyc;
    s_key_enter = 1'b1;
    @(posedge Clk); #1;
    s_key_enter = 1'b0;
    n = 0;
    while (!s_fb_valid && n < 30) begin
      @(negedge Clk);
      n++;
    end
    check("s_fb_seen", 64'(s_fb_valid), 64'(1));
    check("s_fb_code", 64'(s_fb_code), 64'(fb));
    check("s_fb_latency", 64'(cyc), 64'(t + 2 + 3));
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    start = 0; key_valid = 0; key_bksp = 0; key_enter = 0; key_char = '0; target_word = '0;
    s_start = 0; s_key_valid = 0; s_key_bksp = 0; s_key_enter = 0; s_key_char = '0;
    s_target_word = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_key_ready", 64'(key_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'({win, lose, done, fb_valid, enter_reject}), 64'(0));
    check("rst_counts", 64'({letter_cnt, guess_num}), 64'(0));
    check("rst_guess_word", 64'(guess_word), 64'(0));
    check("rst_fb_code", 64'(fb_code), 64'(0));
    reset = 1'b1;
    @(posedge Clk); #1;
    check("idle_key_ready", 64'(key_ready), 64'(0));
    key(1'b1, "Q", 1'b0, 1'b0);
    check("idle_key_ignored", 64'(letter_cnt), 64'(0));

    // Game 1: target ABBOT
    start_game("ABBOT");
    check("g1_key_ready", 64'(key_ready), 64'(1));
    type_word("BOBBY");
    check("g1_guess_word", 64'(guess_word), 64'("BOBBY"));
    check("g1_letter_cnt", 64'(letter_cnt), 64'(5));
    submit(10'b01_01_10_00_00, 1'b0);
    check("g1_busy", 64'({busy, key_ready}), 64'(2'b10));
    wait_fb();
    check("g1_back_entry", 64'(key_ready), 64'(1));
    check("g1_guess_num", 64'(guess_num), 64'(1));
    check("g1_buf_cleared", 64'({guess_word, letter_cnt}), 64'(0));
    check("g1_fb_held", 64'(fb_code), 64'(10'b01_01_10_00_00));
    check("g1_no_win", 64'({win, lose, done}), 64'(0));

    // Short enter, overflow letter, combined keys, keys while busy
    type_word({"ABC", 16'h0}); // two zero "letters" would be typed: avoid, retype below
    key(1'b0, 8'h00, 1'b1, 1'b0);
    key(1'b0, 8'h00, 1'b1, 1'b0);
    check("bksp_cnt", 64'(letter_cnt), 64'(3));
    key(1'b0, 8'h00, 1'b0, 1'b1);
    check("reject_pulse", 64'(enter_reject), 64'(1));
    check("reject_state", 64'({key_ready, busy}), 64'(2'b10));
    check("reject_cnt", 64'(letter_cnt), 64'(3));
    @(posedge Clk); #1;
    check("reject_one_cycle", 64'(enter_reject), 64'(0));
    key(1'b1, "D", 1'b0, 1'b0);
    key(1'b1, "E", 1'b0, 1'b0);
    key(1'b1, "F", 1'b0, 1'b0);
    check("overflow_cnt", 64'(letter_cnt), 64'(5));
    check("overflow_word", 64'(guess_word), 64'("ABCDE"));
    submit(10'b10_10_00_00_00, 1'b1);
    @(posedge Clk); #1;
    key(1'b1, "Z", 1'b0, 1'b0);
    key(1'b0, 8'h00, 1'b1, 1'b0);
    check("busy_keys_dropped", 64'(guess_word), 64'("ABCDE"));
    check("busy_during_y", 64'(busy), 64'(1));
    wait_fb();
    check("g1_guess_num2", 64'(guess_num), 64'(2));

    // start in ENTRY must not resample the target
    start_game("ROBOT");
    check("start_ignored", 64'({key_ready, guess_num}), 64'({1'b1, 3'd2}));
    type_word("ABBOT");
    submit(10'b10_10_10_10_10, 1'b0);
    wait_fb();
    check("g1_win", 64'({win, lose, done}), 64'(3'b101));
    check("g1_win_num", 64'(guess_num), 64'(3));
    check("g1_done_ready", 64'(key_ready), 64'(0));

    // Game 2: target ROBOT with an edit
    start_game("ROBOT");
    check("g2_cleared", 64'({win, lose, done, fb_code, guess_num}), 64'(0));
    check("g2_ready", 64'({key_ready, guess_word}), 64'({1'b1, 40'h0}));
    key(1'b1, "R", 1'b0, 1'b0);
    key(1'b1, "O", 1'b0, 1'b0);
    key(1'b1, "B", 1'b0, 1'b0);
    key(1'b1, "I", 1'b0, 1'b0);
    key(1'b0, 8'h00, 1'b1, 1'b0);
    check("g2_bksp_word", 64'(guess_word), 64'({"ROB", 16'h0}));
    key(1'b1, "O", 1'b0, 1'b0);
    key(1'b1, "T", 1'b0, 1'b0);
    check("g2_word", 64'(guess_word), 64'("ROBOT"));
    submit(10'b10_10_10_10_10, 1'b0);
    wait_fb();
    check("g2_win", 64'({win, lose, done}), 64'(3'b101));
    check("g2_num", 64'(guess_num), 64'(1));
    check("g2_word_held", 64'(guess_word), 64'("ROBOT"));

    // Game 3: six misses against RENEW
    start_game("RENEW");
    key(1'b0, 8'h00, 1'b1, 1'b0);
    check("bksp_at_zero", 64'(letter_cnt), 64'(0));
    for (int g = 0; g < 6; g++) begin
      type_word("CRIMP");
      submit(10'b00_01_00_00_00, 1'b0);
      wait_fb();
      if (g < 5) check("g3_continue", 64'({key_ready, lose, guess_num}), 64'({1'b1, 1'b0, 3'(g + 1)}));
    end
    check("g3_lose", 64'({win, lose, done}), 64'(3'b011));
    check("g3_num", 64'(guess_num), 64'(6));
    key(1'b1, "X", 1'b0, 1'b0);
    check("done_keys_ignored", 64'({letter_cnt, done}), 64'({3'd5, 1'b1}));
    start_game("ROBOT");
    check("g4_restart", 64'({key_ready, guess_num, lose}), 64'({1'b1, 3'd0, 1'b0}));

    // Reset in the middle of scoring
    type_word("CRIMP");
    key(1'b0, 8'h00, 1'b0, 1'b1);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("pre_reset_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    check("mid_rst_flags", 64'({busy, key_ready, done, win, lose}), 64'(0));
    check("mid_rst_state", 64'({guess_word, letter_cnt, guess_num}), 64'(0));
    repeat (10) @(posedge Clk);
    #1;
    reset = 1'b1;
    @(posedge Clk); #1;
    check("post_rst_idle", 64'({key_ready, busy}), 64'(0));
    repeat (10) @(posedge Clk);
    #1;
    check("sb_empty", 64'(sb_q.size()), 64'(0));

    // Reduced build: CAT then DOG
    s_target_word = "CAT"; s_start = 1'b1;
    @(posedge Clk); #1;
    s_start = 1'b0;
    check("s_ready", 64'(s_key_ready), 64'(1));
    s_type("TAC");
    s_submit(6'b01_10_01);
    check("s_continue", 64'({s_key_ready, s_guess_num}), 64'({1'b1, 2'd1}));
    s_type("CAT");
    s_submit(6'b10_10_10);
    check("s_win", 64'({s_win, s_lose, s_done}), 64'(3'b101));
    s_target_word = "DOG"; s_start = 1'b1;
    @(posedge Clk); #1;
    s_start = 1'b0;
    s_type("CAT");
    s_submit(6'b00_00_00);
    check("s_after1", 64'({s_key_ready, s_lose}), 64'(2'b10));
    s_type("CAT");
    s_submit(6'b00_00_00);
    check("s_lose", 64'({s_win, s_lose, s_done, s_guess_num}), 64'({3'b011, 2'd2}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
